// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op field layout, size and
// exception codes, FSM states and the request classifier.
package lsu_pkg;

    localparam int unsigned OP_STORE    = 3;
    localparam int unsigned OP_UNSIGNED = 2;
    localparam int unsigned OP_SIZE_LSB = 0;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_LD_MIS  = 2'd1,
        EXC_ST_MIS  = 2'd2,
        EXC_ILLEGAL = 2'd3
    } exc_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Illegal encodings win over misalignment.
    function automatic exc_t classify(input logic [3:0] op, input logic [1:0] lo);
        logic       st;
        logic       uns;
        logic [1:0] sz;
        st  = op[OP_STORE];
        uns = op[OP_UNSIGNED];
        sz  = op[OP_SIZE_LSB +: 2];
        if (sz == SZ_BAD || (st && uns) || (sz == SZ_WORD && uns))
            return EXC_ILLEGAL;
        if ((sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && lo != 2'b00))
            return st ? EXC_ST_MIS : EXC_LD_MIS;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication and byte mask, and
// load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_mask,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rdata[7:0];
        case (lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        st_data = wdata;
        st_mask = 4'b1111;
        ld_data = rdata;
        case (size)
            SZ_BYTE: begin
                st_data = {4{wdata[7:0]}};
                st_mask = 4'b0001 << lo;
                ld_data = uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                st_data = {2{wdata[15:0]}};
                st_mask = 4'b0011 << lo;
                ld_data = uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                st_data = wdata;
                st_mask = 4'b1111;
                ld_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory op, drives a single-cycle
// data memory access, and returns the result over a ready/valid handshake.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned WORD_ADDR = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_ld_wen,
    output logic        mem_st_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_is_load,
    output logic [1:0]  out_exc
);

    state_t      state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    exc_t        exc_q;
    exc_t        new_exc;
    logic        accept;
    logic [31:0] mem_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [31:0] ld_data;

    assign in_ready = reset && ((state == IDLE) || (state == RESP && out_ready));
    assign accept   = in_valid && in_ready;
    assign new_exc  = classify(in_op, in_addr[1:0]);

    assign mem_addr  = (WORD_ADDR != 0) ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
    assign mem_raddr = mem_addr;
    assign mem_waddr = mem_addr;
    assign mem_wmask = mem_st_wen ? {4'b0000, st_mask} : '0;
    assign mem_wdata = mem_st_wen ? st_data : '0;

    lsu_align u_align (
        .size    (op_q[OP_SIZE_LSB +: 2]),
        .uns     (op_q[OP_UNSIGNED]),
        .lo      (addr_q[1:0]),
        .wdata   (wdata_q),
        .rdata   (mem_rdata),
        .st_data (st_data),
        .st_mask (st_mask),
        .ld_data (ld_data)
    );

    // Enables are registered at accept so they are high for exactly the
    // ACCESS cycle, and the async reset clears them mid-access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            exc_q       <= EXC_NONE;
            mem_ld_wen  <= 1'b0;
            mem_st_wen  <= 1'b0;
            out_valid   <= 1'b0;
            out_rdata   <= '0;
            out_rd      <= '0;
            out_is_load <= 1'b0;
            out_exc     <= '0;
        end else begin
            mem_ld_wen <= 1'b0;
            mem_st_wen <= 1'b0;
            if (accept) begin
                op_q       <= in_op;
                addr_q     <= in_addr;
                wdata_q    <= in_wdata;
                rd_q       <= in_rd;
                exc_q      <= new_exc;
                mem_ld_wen <= (new_exc == EXC_NONE) && !in_op[OP_STORE];
                mem_st_wen <= (new_exc == EXC_NONE) && in_op[OP_STORE];
            end
            case (state)
                IDLE: begin
                    if (accept)
                        state <= ACCESS;
                end
                ACCESS: begin
                    state       <= RESP;
                    out_valid   <= 1'b1;
                    out_rd      <= rd_q;
                    out_exc     <= exc_q;
                    out_is_load <= !op_q[OP_STORE];
                    out_rdata   <= (!op_q[OP_STORE] && exc_q == EXC_NONE) ? ld_data : '0;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? ACCESS : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a byte-lane reference model.
module tb_lsu_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_ld_wen;
    logic        mem_st_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_is_load;
    logic [1:0]  out_exc;

    lsu_ctrl #(.WORD_ADDR(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_rd       (in_rd),
        .mem_ld_wen  (mem_ld_wen),
        .mem_st_wen  (mem_st_wen),
        .mem_raddr   (mem_raddr),
        .mem_waddr   (mem_waddr),
        .mem_rdata   (mem_rdata),
        .mem_wmask   (mem_wmask),
        .mem_wdata   (mem_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rdata   (out_rdata),
        .out_rd      (out_rd),
        .out_is_load (out_is_load),
        .out_exc     (out_exc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ld;
        logic [31:0] st;
        logic [31:0] exc;
        logic [31:0] addr;
        logic [31:0] mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] is_load;
    } exp_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        cur;
    logic [4:0]  cur_rd;
    bit          pending = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected behaviour from access size in bytes and byte offset within the word.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rword);
        exp_t        e;
        int unsigned n;
        int unsigned off;
        bit          store;
        bit          uns;
        longint      v;
        e = '{default: '0};
        store = op[3];
        uns = op[2];
        n = 1 << op[1:0];
        off = addr % 4;
        e.is_load = {31'd0, !store};
        e.addr = addr / 4;
        if (op[1:0] == 2'b11 || (store && uns) || (n == 4 && uns))
            e.exc = 3;
        else if (addr % n != 0)
            e.exc = store ? 2 : 1;
        if (e.exc == 0) begin
            if (store) begin
                e.st = 1;
                for (int unsigned i = 0; i < 4; i++) begin
                    if (i >= off && i < off + n) e.mask[i] = 1'b1;
                    e.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
                end
            end else begin
                e.ld = 1;
                v = (longint'(rword) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
                if (!uns && v[8*n-1]) v = v - (64'sd1 << (8 * n));
                e.rdata = v[31:0];
            end
        end
        return e;
    endfunction

    task automatic start_op(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd,
                            input logic [31:0] rword);
        in_valid = 1'b1;
        in_op = op;
        in_addr = addr;
        in_wdata = wdata;
        in_rd = rd;
        mem_rdata = rword;
        cur = model(op, addr, wdata, rword);
        cur_rd = rd;
        #1 chk("in_ready_pre", {31'd0, in_ready}, 1);
    endtask

    task automatic check_resp();
        chk("resp_valid", {31'd0, out_valid}, 1);
        chk("resp_rdata", out_rdata, cur.rdata);
        chk("resp_rd", {27'd0, out_rd}, {27'd0, cur_rd});
        chk("resp_exc", {30'd0, out_exc}, cur.exc);
        chk("resp_is_load", {31'd0, out_is_load}, cur.is_load);
        chk("resp_ld_wen", {31'd0, mem_ld_wen}, 0);
        chk("resp_st_wen", {31'd0, mem_st_wen}, 0);
        chk("resp_wmask", {24'd0, mem_wmask}, 0);
        chk("resp_in_ready", {31'd0, in_ready}, 0);
    endtask

    task automatic after_accept(input int unsigned hold);
        @(posedge clock);
        #1;
        chk("acc_out_valid", {31'd0, out_valid}, 0);
        chk("acc_in_ready", {31'd0, in_ready}, 0);
        chk("ld_wen", {31'd0, mem_ld_wen}, cur.ld);
        chk("st_wen", {31'd0, mem_st_wen}, cur.st);
        if (cur.ld != 0) chk("raddr", mem_raddr, cur.addr);
        if (cur.st != 0) chk("waddr", mem_waddr, cur.addr);
        chk("wmask", {24'd0, mem_wmask}, cur.mask);
        chk("wdata", mem_wdata, cur.wdata);
        @(negedge clock);
        in_valid = 1'b0;
        in_op = 4'($urandom);
        in_addr = $urandom;
        in_wdata = $urandom;
        in_rd = 5'($urandom);
        out_ready = 1'b0;
        @(posedge clock);
        #1 check_resp();
        for (int unsigned k = 0; k < hold; k++) begin
            @(negedge clock);
            mem_rdata = $urandom;
            @(posedge clock);
            #1 check_resp();
        end
    endtask

    task automatic release_resp();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("rel_out_valid", {31'd0, out_valid}, 0);
        chk("rel_in_ready", {31'd0, in_ready}, 1);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] rword,
                       input int unsigned hold, input bit chain);
        if (pending && !chain) begin
            release_resp();
        end else begin
            @(negedge clock);
            if (pending) out_ready = 1'b1;
        end
        start_op(op, addr, wdata, rd, rword);
        after_accept(hold);
        pending = 1;
    endtask

    initial begin
        logic [31:0] a;
        in_valid = 1'b1;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_ld_wen", {31'd0, mem_ld_wen}, 0);
        chk("rst_st_wen", {31'd0, mem_st_wen}, 0);
        chk("rst_wmask", {24'd0, mem_wmask}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_out_rdata", out_rdata, 0);
        chk("rst_out_rd", {27'd0, out_rd}, 0);
        chk("rst_out_exc", {30'd0, out_exc}, 0);
        chk("rst_is_load", {31'd0, out_is_load}, 0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_waddr", mem_waddr, 0);
        #10;
        in_valid = 1'b0;
        reset = 1'b1;

        run(4'b1000, 32'h103, 32'h000000AB, 5'd1, 32'h0, 0, 0);
        chk("sb_mask_const", {24'd0, mem_wmask}, 0);
        run(4'b0000, 32'h102, 32'h0, 5'd2, 32'h12F45678, 0, 0);
        chk("lb_const", out_rdata, 32'hFFFFFFF4);
        run(4'b0100, 32'h102, 32'h0, 5'd3, 32'h12F45678, 0, 0);
        chk("lbu_const", out_rdata, 32'h000000F4);
        run(4'b0010, 32'h106, 32'h0, 5'd4, 32'hDEADBEEF, 0, 0);
        run(4'b1001, 32'h101, 32'h1234, 5'd5, 32'h0, 0, 0);
        run(4'b0011, 32'h100, 32'h0, 5'd6, 32'h0, 0, 0);
        run(4'b1001, 32'h102, 32'hCAFEBEEF, 5'd7, 32'h0, 3, 0);
        run(4'b0001, 32'h0FE, 32'h0, 5'd8, 32'h8001_7FFF, 0, 1);
        run(4'b1010, 32'h0F0, 32'h89ABCDEF, 5'd9, 32'h0, 1, 1);
        release_resp();
        pending = 0;

        start_op(4'b1010, 32'h200, 32'h55AA55AA, 5'd10, 32'h0);
        @(posedge clock);
        #1 chk("abort_st_wen_pre", {31'd0, mem_st_wen}, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_st_wen", {31'd0, mem_st_wen}, 0);
        chk("abort_wmask", {24'd0, mem_wmask}, 0);
        chk("abort_out_valid", {31'd0, out_valid}, 0);
        chk("abort_in_ready", {31'd0, in_ready}, 0);
        reset = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("post_abort_valid", {31'd0, out_valid}, 0);
        chk("post_abort_in_ready", {31'd0, in_ready}, 1);
        chk("post_abort_st_wen", {31'd0, mem_st_wen}, 0);
        run(4'b0110, 32'h202, 32'h0, 5'd11, 32'hFEDC_0000, 0, 0);

        for (int unsigned t = 0; t < 300; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run(4'($urandom_range(0, 15)), a, $urandom, 5'($urandom), $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        release_resp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
